// File: rtl/snapshot_register_file.sv
// Multi-port register file with per-register ready bits and a one-entry
// checkpoint shadow. Define SNAPSHOT_RF_RD_BYPASS_EN for same-cycle write-to-read bypass.

module snapshot_rf_cell #(
  parameter int DATA_W = 8,
  parameter int AW     = 2,
  parameter int NUM_WR = 2,
  parameter int IDX    = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_WR-1:0]        wr_call,
  input  logic [NUM_WR*AW-1:0]     wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     alloc_call,
  input  logic [AW-1:0]            alloc_addr,
  input  logic                     save,
  input  logic                     restore,
  output logic [DATA_W-1:0]        q,
  output logic                     rdy
);
  localparam logic [AW-1:0] MY = AW'(IDX);

  logic              hit, alloc_hit, srdy;
  logic [DATA_W-1:0] wval, sq;

  // Ascending scan: the last (highest) matching port overrides lower ones.
  always_comb begin
    hit  = 1'b0;
    wval = q;
    for (int p = 0; p < NUM_WR; p++) begin
      if (wr_call[p] && wr_addr[p*AW +: AW] == MY) begin
        hit  = 1'b1;
        wval = wr_data[p*DATA_W +: DATA_W];
      end
    end
  end

  assign alloc_hit = alloc_call && (alloc_addr == MY);

  always_ff @(posedge clk) begin
    if (reset) begin
      q    <= '0;
      rdy  <= 1'b1;
      sq   <= '0;
      srdy <= 1'b1;
    end else if (restore) begin
      q   <= sq;
      rdy <= srdy;
    end else begin
      if (hit) q <= wval;
      // Alloc beats a same-cycle write for the ready bit.
      if (alloc_hit) rdy <= 1'b0;
      else if (hit)  rdy <= 1'b1;
      if (save) begin
        sq   <= q;
        srdy <= rdy;
      end
    end
  end
endmodule

module snapshot_register_file #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 4,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic [NUM_WR-1:0]        wr_call,
  input  logic [NUM_WR*AW-1:0]     wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     alloc_call,
  input  logic [AW-1:0]            alloc_addr,
  output logic [NREGS-1:0]         ready,
  input  logic                     snap_save,
  input  logic                     snap_restore,
  output logic                     snap_valid,
  output logic [NREGS*DATA_W-1:0]  dump_out
);
  logic [NREGS-1:0][DATA_W-1:0] regs;
  logic                         restore_eff, save_eff;

  // A restore without a held snapshot is a no-op; a live restore swallows save.
  assign restore_eff = snap_restore && snap_valid;
  assign save_eff    = snap_save && !restore_eff;

  for (genvar r = 0; r < NREGS; r++) begin : g_reg
    snapshot_rf_cell #(
      .DATA_W(DATA_W), .AW(AW), .NUM_WR(NUM_WR), .IDX(r)
    ) u_cell (
      .clk       (clk),
      .reset     (reset),
      .wr_call   (wr_call),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .alloc_call(alloc_call),
      .alloc_addr(alloc_addr),
      .save      (save_eff),
      .restore   (restore_eff),
      .q         (regs[r]),
      .rdy       (ready[r])
    );
  end

  always_ff @(posedge clk) begin
    if (reset)            snap_valid <= 1'b0;
    else if (restore_eff) snap_valid <= 1'b0;
    else if (snap_save)   snap_valid <= 1'b1;
  end

  assign dump_out = regs;

  always_comb begin
    rd_data = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      rd_data[p*DATA_W +: DATA_W] = regs[rd_addr[p*AW +: AW]];
`ifdef SNAPSHOT_RF_RD_BYPASS_EN
      for (int w = 0; w < NUM_WR; w++) begin
        if (!restore_eff && wr_call[w] && wr_addr[w*AW +: AW] == rd_addr[p*AW +: AW])
          rd_data[p*DATA_W +: DATA_W] = wr_data[w*DATA_W +: DATA_W];
      end
`endif
    end
  end
endmodule

// File: tb/tb_snapshot_register_file.sv
// Directed bench for snapshot_register_file: array-based reference model checked
// every cycle, plus literal expectations from hand-worked scenarios.

module tb_snapshot_register_file;
  localparam int DW = 8, NR = 4, NRD = 2, NWR = 2, AW = 2;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [NRD*AW-1:0]   rd_addr = '0;
  logic [NRD*DW-1:0]   rd_data;
  logic [NWR-1:0]      wr_call = '0;
  logic [NWR*AW-1:0]   wr_addr = '0;
  logic [NWR*DW-1:0]   wr_data = '0;
  logic                alloc_call = 1'b0;
  logic [AW-1:0]       alloc_addr = '0;
  logic [NR-1:0]       ready;
  logic                snap_save = 1'b0, snap_restore = 1'b0;
  logic                snap_valid;
  logic [NR*DW-1:0]    dump_out;

  int checks = 0, errors = 0;

  snapshot_register_file #(.DATA_W(DW), .NREGS(NR), .NUM_RD(NRD), .NUM_WR(NWR)) dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_call(wr_call), .wr_addr(wr_addr), .wr_data(wr_data),
    .alloc_call(alloc_call), .alloc_addr(alloc_addr), .ready(ready),
    .snap_save(snap_save), .snap_restore(snap_restore),
    .snap_valid(snap_valid), .dump_out(dump_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: state as plain arrays, updated by the rules directly.
  logic [DW-1:0] m_regs[NR], m_sregs[NR];
  logic          m_rdy[NR], m_srdy[NR];
  logic          m_valid = 1'b0;
  logic          chk_en = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NR; r++) begin
        m_regs[r] = '0; m_rdy[r] = 1'b1; m_sregs[r] = '0; m_srdy[r] = 1'b1;
      end
      m_valid = 1'b0;
      chk_en  = 1'b1;
    end else if (snap_restore && m_valid) begin
      m_regs  = m_sregs;
      m_rdy   = m_srdy;
      m_valid = 1'b0;
    end else begin
      if (snap_save) begin
        m_sregs = m_regs;
        m_srdy  = m_rdy;
        m_valid = 1'b1;
      end
      for (int w = 0; w < NWR; w++)
        if (wr_call[w]) begin
          m_regs[wr_addr[w*AW +: AW]] = wr_data[w*DW +: DW];
          m_rdy[wr_addr[w*AW +: AW]]  = 1'b1;
        end
      if (alloc_call) m_rdy[alloc_addr] = 1'b0;
    end
  end

  function automatic logic [DW-1:0] model_rd(input int p);
    logic [AW-1:0] a;
    logic [DW-1:0] v;
    a = rd_addr[p*AW +: AW];
    v = m_regs[a];
`ifdef SNAPSHOT_RF_RD_BYPASS_EN
    if (!(snap_restore && m_valid))
      for (int w = 0; w < NWR; w++)
        if (wr_call[w] && wr_addr[w*AW +: AW] == a) v = wr_data[w*DW +: DW];
`endif
    return v;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      logic [NR-1:0]    er;
      logic [NR*DW-1:0] ed;
      for (int r = 0; r < NR; r++) begin
        er[r] = m_rdy[r];
        ed[r*DW +: DW] = m_regs[r];
      end
      check("model_ready", 64'(ready), 64'(er));
      check("model_dump", 64'(dump_out), 64'(ed));
      check("model_snap_valid", 64'(snap_valid), 64'(m_valid));
      for (int p = 0; p < NRD; p++)
        check("model_rd_data", 64'(rd_data[p*DW +: DW]), 64'(model_rd(p)));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_call = '0; alloc_call = 1'b0; snap_save = 1'b0; snap_restore = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] byp_exp;
    reset = 1'b1;
    step(); step();
    reset = 1'b0;

    check("rst_ready", 64'(ready), 64'(4'b1111));
    check("rst_snap_valid", 64'(snap_valid), 64'(1'b0));
    check("rst_dump", 64'(dump_out), 64'(32'h0));
    for (int a = 0; a < NR; a++) begin
      rd_addr = {2'(a), 2'(a)};
      #1;
      check("rst_rd0", 64'(rd_data[7:0]), 64'(8'h00));
      check("rst_rd1", 64'(rd_data[15:8]), 64'(8'h00));
    end

    // Both ports hit reg 2; port 1 must win.
    wr_call = 2'b11; wr_addr = {2'd2, 2'd2}; wr_data = {8'h22, 8'h11};
    rd_addr = {2'd0, 2'd2};
    #1;
`ifdef SNAPSHOT_RF_RD_BYPASS_EN
    byp_exp = 8'h22;
`else
    byp_exp = 8'h00;
`endif
    check("same_cycle_rd", 64'(rd_data[7:0]), 64'(byp_exp));
    step(); idle();
    check("prio_reg2", 64'(dump_out[23:16]), 64'(8'h22));
    check("prio_rd", 64'(rd_data[7:0]), 64'(8'h22));

    alloc_call = 1'b1; alloc_addr = 2'd1;
    step(); idle();
    check("alloc_ready", 64'(ready), 64'(4'b1101));
    wr_call = 2'b01; wr_addr = {2'd0, 2'd1}; wr_data = {8'h00, 8'h5A};
    step(); idle();
    check("write_ready", 64'(ready), 64'(4'b1111));
    check("write_reg1", 64'(dump_out[15:8]), 64'(8'h5A));

    alloc_call = 1'b1; alloc_addr = 2'd3;
    wr_call = 2'b10; wr_addr = {2'd3, 2'd0}; wr_data = {8'h77, 8'h00};
    step(); idle();
    check("alloc_wins_ready", 64'(ready), 64'(4'b0111));
    check("alloc_wins_reg3", 64'(dump_out[31:24]), 64'(8'h77));

    wr_call = 2'b11; wr_addr = {2'd1, 2'd0}; wr_data = {8'h02, 8'h01};
    step();
    wr_addr = {2'd3, 2'd2}; wr_data = {8'h04, 8'h03};
    step(); idle();
    snap_save = 1'b1;
    step(); idle();
    check("save_valid", 64'(snap_valid), 64'(1'b1));
    wr_call = 2'b01; wr_addr = {2'd0, 2'd0}; wr_data = {8'h00, 8'hFF};
    alloc_call = 1'b1; alloc_addr = 2'd2;
    step(); idle();
    check("post_save_dump", 64'(dump_out), 64'(32'h040302FF));
    check("post_save_ready", 64'(ready), 64'(4'b1011));
    snap_restore = 1'b1;
    step(); idle();
    check("restore_dump", 64'(dump_out), 64'(32'h04030201));
    check("restore_ready", 64'(ready), 64'(4'b1111));
    check("restore_valid", 64'(snap_valid), 64'(1'b0));

    // Restore with nothing saved behaves like a plain cycle.
    snap_restore = 1'b1;
    wr_call = 2'b01; wr_addr = {2'd0, 2'd0}; wr_data = {8'h00, 8'h33};
    step(); idle();
    check("noval_restore_reg0", 64'(dump_out[7:0]), 64'(8'h33));
    check("noval_restore_valid", 64'(snap_valid), 64'(1'b0));

    snap_save = 1'b1;
    step(); idle();
    snap_save = 1'b1; snap_restore = 1'b1;
    wr_call = 2'b10; wr_addr = {2'd1, 2'd0}; wr_data = {8'h99, 8'h00};
    rd_addr = {2'd1, 2'd1};
    #1;
    check("restore_blocks_bypass", 64'(rd_data[15:8]), 64'(8'h02));
    step(); idle();
    check("save_restore_dump", 64'(dump_out), 64'(32'h04030233));
    check("save_restore_valid", 64'(snap_valid), 64'(1'b0));

    snap_save = 1'b1;
    step(); idle();
    wr_call = 2'b01; wr_addr = {2'd0, 2'd2}; wr_data = {8'h00, 8'hAB};
    step(); idle();
    reset = 1'b1; snap_restore = 1'b1;
    step(); idle();
    reset = 1'b0;
    check("reset_restore_dump", 64'(dump_out), 64'(32'h0));
    check("reset_restore_ready", 64'(ready), 64'(4'b1111));
    check("reset_restore_valid", 64'(snap_valid), 64'(1'b0));
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
